// File: rtl/lbc_cap_pkg.sv
// Shared definitions for the LED-band serial capture block: default geometry,
// drain FSM states and the bit_count width helper.
package lbc_cap_pkg;

    localparam int CH_DEFAULT   = 16;
    localparam int BITS_DEFAULT = 16;

    typedef enum logic {IDLE, DRAIN} cap_state_t;

    // One spare bit beyond what SR_BITS needs, so an over-long frame stays visible
    function automatic int bc_width(input int srBits);
        return $clog2(srBits + 1) + 1;
    endfunction

endpackage

// File: rtl/lbc_sync_edge.sv
// Two-flop synchronizer with a one-cycle rise pulse on the synchronized signal.
module lbc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign s    = r_sync;
    assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/lbc_serial_capture.sv
// Rebuilds the LED-driver shift-register image from SCLK/SOUT/LAT and replays it
// per channel on a valid/ready stream. Optional GCLK counter: LBC_CAP_GCLK_COUNT_EN.
module lbc_serial_capture
    import lbc_cap_pkg::*;
#(
    parameter int CH      = CH_DEFAULT,
    parameter int BITS    = BITS_DEFAULT,
    parameter int SR_BITS = CH * BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sclk_in,
    input  logic                           sin,
    input  logic                           lat_in,
    input  logic                           gclk_in,
    output logic [BITS-1:0]                out_data,
    output logic [$clog2(CH)-1:0]          out_ch,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [bc_width(SR_BITS)-1:0]   bit_count,
    output logic                           len_err,
    output logic                           overrun_err
`ifdef LBC_CAP_GCLK_COUNT_EN
    ,
    output logic [31:0]                    gclk_count
`endif
);

    localparam int                BC_W      = bc_width(SR_BITS);
    localparam int                CH_W      = $clog2(CH);
    localparam logic [BC_W-1:0]   SR_BITS_C = BC_W'(SR_BITS);
    localparam logic [BC_W-1:0]   RUN_MAX   = '1;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH - 1);

    cap_state_t r_state;
    cap_state_t w_stateNext;

    logic [SR_BITS-1:0] r_sr;
    logic [SR_BITS-1:0] r_latImg;
    logic [BC_W-1:0]    r_runCnt;
    logic [BC_W-1:0]    r_bitCount;
    logic [CH_W-1:0]    r_ch;
    logic               r_lenErr;
    logic               r_overrunErr;

    logic               w_sclkS;
    logic               w_sclkRise;
    logic               w_sinS;
    logic               w_sinRise;
    logic               w_latS;
    logic               w_latRise;
    logic               w_outValid;
    logic               w_latchAccept;
    logic               w_handshake;
    logic [SR_BITS-1:0] w_srNext;
    logic [BC_W-1:0]    w_runNext;
    logic [BITS-1:0]    w_words [CH];
    logic               w_unusedSync;

    lbc_sync_edge u_sclkSync (.clk(clk), .rst(rst), .d(sclk_in), .s(w_sclkS), .rise(w_sclkRise));
    lbc_sync_edge u_sinSync  (.clk(clk), .rst(rst), .d(sin),     .s(w_sinS),  .rise(w_sinRise));
    lbc_sync_edge u_latSync  (.clk(clk), .rst(rst), .d(lat_in),  .s(w_latS),  .rise(w_latRise));

    assign w_unusedSync = w_sclkS & w_sinRise & w_latS;

    // The shift lands before a coincident latch, so the copy sees that bit
    assign w_srNext  = w_sclkRise ? {r_sr[SR_BITS-2:0], w_sinS} : r_sr;
    assign w_runNext = (w_sclkRise && (r_runCnt != RUN_MAX)) ? r_runCnt + 1'b1 : r_runCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_outValid    = 1'b0;
        w_latchAccept = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_latRise) begin
                    w_latchAccept = 1'b1;
                    w_stateNext   = DRAIN;
                end
            end
            DRAIN: begin
                w_outValid = 1'b1;
                if (out_ready && (r_ch == LAST_CH)) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign w_handshake = w_outValid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr         <= '0;
            r_latImg     <= '0;
            r_runCnt     <= '0;
            r_bitCount   <= '0;
            r_ch         <= '0;
            r_lenErr     <= 1'b0;
            r_overrunErr <= 1'b0;
        end else begin
            r_sr     <= w_srNext;
            r_runCnt <= w_latRise ? '0 : w_runNext;
            if (w_latchAccept) begin
                r_latImg   <= w_srNext;
                r_bitCount <= w_runNext;
                r_lenErr   <= (w_runNext != SR_BITS_C);
                r_ch       <= '0;
            end else if (w_handshake && (r_ch != LAST_CH)) begin
                r_ch <= r_ch + 1'b1;
            end
            // A latch during drain is dropped; only the sticky flag records it
            if (w_latRise && (r_state == DRAIN)) begin
                r_overrunErr <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_word
        assign w_words[g] = r_latImg[SR_BITS-1-g*BITS -: BITS];
    end

    assign out_data    = w_words[r_ch];
    assign out_ch      = r_ch;
    assign out_last    = w_outValid & (r_ch == LAST_CH);
    assign out_valid   = w_outValid;
    assign bit_count   = r_bitCount;
    assign len_err     = r_lenErr;
    assign overrun_err = r_overrunErr;

`ifdef LBC_CAP_GCLK_COUNT_EN
    logic        w_gclkS;
    logic        w_gclkRise;
    logic [31:0] r_gclkCnt;
    logic [31:0] r_gclkCount;
    logic        w_unusedGclk;

    lbc_sync_edge u_gclkSync (.clk(clk), .rst(rst), .d(gclk_in), .s(w_gclkS), .rise(w_gclkRise));

    assign w_unusedGclk = w_gclkS;

    // A GCLK rise sharing the latch cycle opens the new interval
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gclkCnt   <= '0;
            r_gclkCount <= '0;
        end else if (w_latchAccept) begin
            r_gclkCount <= r_gclkCnt;
            r_gclkCnt   <= {31'd0, w_gclkRise};
        end else if (w_gclkRise) begin
            r_gclkCnt <= r_gclkCnt + 32'd1;
        end
    end

    assign gclk_count = r_gclkCount;
`else
    logic w_unusedGclk;
    assign w_unusedGclk = gclk_in;
`endif

endmodule

// File: doc/lbc_serial_capture.md
# lbc_serial_capture

Receiving end of the LED-band serial link. The block samples the SCLK/SOUT/LAT stream that drives the LED driver chips and rebuilds the shift-register image. On each LAT it replays the latched image as per-channel grayscale words through a valid/ready stream, and it flags framing errors. It sits in benches and debug tops next to `led_band_controller`, acting as the bit-exact model of the driver-chip input stage.

## Interface
- `CH`, default 16: channels per latch image.
- `BITS`, default 16: bits per channel.
- `SR_BITS`, default `CH*BITS`: shift-register length (derived; never overridden).
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `sclk_in`, input, 1: serial clock. Data is shifted on its rising edge.
- `sin`, input, 1: serial data (the controller's SOUT).
- `lat_in`, input, 1: latch strobe, acting on its rising edge.
- `gclk_in`, input, 1: grayscale clock. Used only when `LBC_CAP_GCLK_COUNT_EN` is defined.
- `out_data`, output, `BITS`: channel word.
- `out_ch`, output, `$clog2(CH)`: channel index of `out_data`.
- `out_last`, output, 1: high on channel `CH-1`.
- `out_valid`, output, 1: word valid.
- `out_ready`, input, 1: consumer accepts the word.
- `bit_count`, output, `$clog2(SR_BITS+1)+1`: number of SCLK rises in the last latched frame.
- `len_err`, output, 1: the last latched frame had `bit_count != SR_BITS`.
- `overrun_err`, output, 1: sticky. Set when a LAT arrives while the block is draining.
- `gclk_count`, output, 32: GCLK rises between the last two LATs. Present only when the macro is defined.

## Operation
**Input sampling**
- `sclk_in`, `sin`, `lat_in` and `gclk_in` each pass through a 2-flop synchronizer.
- A rise is `sync2 & ~prev`.
- `sin` goes through the same 2-flop path, so it stays aligned with `sclk_in`.

**Shift path**
- On an SCLK rise: `sr <= {sr[SR_BITS-2:0], sin_s}`. The first bit shifted in ends up as the MSB of channel 0.
- `run_cnt` increments on each SCLK rise and saturates at all-ones.

**FSM states**
- IDLE:
  - On a LAT rise: copy `sr` to `lat_img`, `bit_count <= run_cnt`, `len_err <= (run_cnt != SR_BITS)`, clear `run_cnt`, set `ch <= 0`, go to DRAIN.
- DRAIN:
  - `out_valid = 1`.
  - `out_data = lat_img[SR_BITS-1-ch*BITS -: BITS]`.
  - On `out_valid & out_ready`: `ch++`. If `ch == CH-1`, go to IDLE instead.
  - A LAT rise in DRAIN sets `overrun_err`, clears `run_cnt`, and is otherwise dropped. `lat_img`, `bit_count` and `len_err` are unchanged.

**Simultaneous events**
- SCLK rise and LAT rise in the same cycle: the shift is applied first. The copied image and `bit_count` include that bit, and `run_cnt` restarts at 0.

**Reset**
- Reset clears `sr`, `lat_img`, `run_cnt`, `bit_count`, `ch`, `len_err`, `overrun_err`, `gclk_count` and all synchronizer flops.
- FSM returns to IDLE and `out_valid` = 0.
- A reset mid-drain discards the remaining words.

## Timing
- An input edge present before clk edge k registers its action (shift or latch copy) at edge k+2.
- `out_valid` is high from edge k+2 onward.
- Each SCLK and LAT phase lasts ≥1 clk: the inputs are clk-synchronous in this design.
- With `out_ready` held at 1, a frame drains in exactly `CH` cycles.
- `out_data`, `out_ch` and `out_last` are stable while `out_valid & ~out_ready`.
- `bit_count` and `len_err` update in the same edge as the latch copy and hold until the next accepted LAT.

## Configuration
- `LBC_CAP_GCLK_COUNT_EN` defined:
  - A 32-bit counter counts GCLK rises. It wraps modulo 2^32.
  - On an accepted LAT: `gclk_count <= counter` and the counter is cleared.
  - A GCLK rise in the same cycle as the LAT counts toward the new interval.
- Not defined:
  - The `gclk_count` port and the counter are absent, and `gclk_in` is ignored.

## Structure
- Package `lbc_cap_pkg` holds:
  - the `CH` and `BITS` defaults;
  - `typedef enum logic {IDLE, DRAIN} cap_state_t`;
  - the `bit_count` width function.
- Sub-module `lbc_sync_edge` is a 2-flop synchronizer plus rise detect, with outputs `s` and `rise`. It is instantiated for SCLK, LAT and GCLK; SIN uses its `s` output only.

## Test plan
- **Nominal frame:** shift 256 bits with channel c = 16'h1000+c, then pulse LAT, with `out_ready`=1 → 16 words `16'h1000..16'h100F`, `out_last` on ch 15, `bit_count`=256, `len_err`=0.
- **Backpressure:** same frame with `out_ready` toggling 1/0 every cycle → identical word sequence, with data held stable during stalls; drain takes 31–32 cycles.
- **Short frame:** 250 SCLK rises then LAT → `bit_count`=250, `len_err`=1. The words equal the 250 bits right-aligned, with 6 leading zeros after reset.
- **Overrun:** LAT while `out_ready`=0 with 16 words pending → `overrun_err`=1; the original words still drain unchanged.
- **Coincident SCLK+LAT:** the last (256th) rise shares its cycle with the LAT rise → `bit_count`=256 and the last bit is present in ch 15 LSB.
- **Reset mid-drain plus GCLK:** apply `rst` after 5 words → `out_valid`=0 the next cycle. With `LBC_CAP_GCLK_COUNT_EN` defined, 1000 GCLK rises between two LATs → `gclk_count`=1000.
